// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the regfile_sb register file.
//   - RF_DATA_W / RF_ADDR_W / RF_NUM_RD : default geometry
//   - RF_PORT_SBUS / RF_PORT_ALU        : read-port index assignments
//   - rf_addr_t / rf_data_t             : select and data types at default size
//   Optional feature macro used elsewhere: REGFILE_BYPASS_EN
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;

    // Read port 0 drives the S-bus, read port 1 drives the ALU operand.
    localparam int RF_PORT_SBUS = 0;
    localparam int RF_PORT_ALU  = 1;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// ---------------------------------------------------------------------------
// regfile_rdport
//   One combinational read port of the register file: selects a register
//   and its busy bit, masks register 0 to zero / not-busy, and (when
//   REGFILE_BYPASS_EN is defined) forwards same-cycle write data.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : a write to the selected register is visible this cycle
//     undefined : reads show registered contents only
//
//   Ports
//     sel            in  ADDR_W               register select (0 = zero reg)
//     store          in  (DEPTH-1) x DATA_W   register contents r1..rN
//     busy_vec       in  DEPTH-1              busy bits r1..rN
//     byp_en         in  1                    a write is happening this cycle
//     write_select   in  ADDR_W               write target
//     sbus_in        in  DATA_W               write data
//     rsv_en         in  1                    a valid reservation this cycle
//     reserve_select in  ADDR_W               reservation target
//     data           out DATA_W               read data
//     busy           out 1                    busy flag of selected register
// ---------------------------------------------------------------------------
module regfile_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]             sel,
    input  logic [DEPTH-1:1][DATA_W-1:0]  store,
    input  logic [DEPTH-1:1]              busy_vec,
    input  logic                          byp_en,
    input  logic [ADDR_W-1:0]             write_select,
    input  logic [DATA_W-1:0]             sbus_in,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             reserve_select,
    output logic [DATA_W-1:0]             data,
    output logic                          busy
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data = '0;
        busy = 1'b0;
        if (sel != '0) begin
            data = store[sel];
            busy = busy_vec[sel];
            // Forward the in-flight write. The write clears busy unless a
            // reservation of the same register lands in this same cycle.
            if (byp_en && (write_select == sel)) begin
                data = sbus_in;
                busy = rsv_en && (reserve_select == sel);
            end
        end
    end
`else
    always_comb begin
        data = '0;
        busy = 1'b0;
        if (sel != '0) begin
            data = store[sel];
            busy = busy_vec[sel];
        end
    end

    // Forwarding inputs have no consumer in this build.
    logic unused_bypass;
    assign unused_bypass = &{1'b0, byp_en, write_select, sbus_in,
                             rsv_en, reserve_select};
`endif

endmodule : regfile_rdport

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Clocked register file with one write port, NUM_RD combinational read
//   ports and a per-register busy scoreboard. Register 0 reads as zero and
//   write_select == 0 means "no write".
//
//   Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding)
//
//   Ports
//     clk            in  1              clock, rising edge
//     rst_n          in  1              asynchronous active-low reset
//     sbus_in        in  DATA_W         write data
//     write_select   in  ADDR_W         write target, 0 = no write
//     reserve_en     in  1              mark reserve_select busy
//     reserve_select in  ADDR_W         register to reserve
//     rd_select      in  NUM_RD*ADDR_W  read selects, port p at [p*ADDR_W +: ADDR_W]
//     rd_data        out NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
//     rd_busy        out NUM_RD         busy flag of selected register per port
//     busy_count     out ADDR_W+1       number of busy registers (registered state)
// ---------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        sbus_in,
    input  logic [ADDR_W-1:0]        write_select,
    input  logic                     reserve_en,
    input  logic [ADDR_W-1:0]        reserve_select,
    input  logic [NUM_RD*ADDR_W-1:0] rd_select,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          busy_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Register 0 has no storage; index ranges start at 1.
    logic [DEPTH-1:1][DATA_W-1:0] regs;
    logic [DEPTH-1:1]             busy;

    logic wr_en;
    logic rsv_en;
    logic byp_en;

    assign wr_en  = (write_select != '0);
    assign rsv_en = reserve_en && (reserve_select != '0);
    // Forwarding is suppressed in reset so every output reads zero there.
    assign byp_en = rst_n && wr_en;

    // -----------------------------------------------------------------------
    // Storage and scoreboard. The reservation is applied after the write so
    // that a same-cycle write+reserve of one register leaves it busy.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wr_en) begin
                regs[write_select] <= sbus_in;
                busy[write_select] <= 1'b0;
            end
            if (rsv_en) begin
                busy[reserve_select] <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Busy population count over registered state only.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_count = '0;
        for (int i = 1; i < DEPTH; i++) begin
            busy_count = busy_count + {{ADDR_W{1'b0}}, busy[i]};
        end
    end

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rdport
        regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rdport (
            .sel            (rd_select[p*ADDR_W +: ADDR_W]),
            .store          (regs),
            .busy_vec       (busy),
            .byp_en         (byp_en),
            .write_select   (write_select),
            .sbus_in        (sbus_in),
            .rsv_en         (rsv_en),
            .reserve_select (reserve_select),
            .data           (rd_data[p*DATA_W +: DATA_W]),
            .busy           (rd_busy[p])
        );
    end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Directed bench for regfile_sb at default geometry (32 x 32, 2 read
//   ports). Inputs change 1 time unit after the rising edge; outputs are
//   sampled before the next rising edge. Expectations for bypass depend on
//   whether REGFILE_BYPASS_EN is defined for this build.
// ---------------------------------------------------------------------------
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = RF_DATA_W;
    localparam int AW = RF_ADDR_W;
    localparam int NR = RF_NUM_RD;

    logic             clk;
    logic             rst_n;
    logic [DW-1:0]    sbus_in;
    logic [AW-1:0]    write_select;
    logic             reserve_en;
    logic [AW-1:0]    reserve_select;
    logic [NR*AW-1:0] rd_select;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [AW:0]      busy_count;

    int checks;
    int failures;

    // Scoreboard queue of values written during the sweep, in select order.
    logic [DW-1:0] exp_q[$];

    regfile_sb #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sbus_in        (sbus_in),
        .write_select   (write_select),
        .reserve_en     (reserve_en),
        .reserve_select (reserve_select),
        .rd_select      (rd_select),
        .rd_data        (rd_data),
        .rd_busy        (rd_busy),
        .busy_count     (busy_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_select   = '0;
        sbus_in        = '0;
        reserve_en     = 1'b0;
        reserve_select = '0;
    endtask

    task automatic set_sel(input logic [AW-1:0] s0, input logic [AW-1:0] s1);
        rd_select = {s1, s0};
    endtask

    task automatic write_reg(input logic [AW-1:0] sel, input logic [DW-1:0] val);
        write_select = sel;
        sbus_in      = val;
        cycle();
        idle();
    endtask

    task automatic reserve_reg(input logic [AW-1:0] sel);
        reserve_en     = 1'b1;
        reserve_select = sel;
        cycle();
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // Power-on: reset asserted before the first clock edge.
        set_sel(5'd2, 5'd3);
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_count !== '0) begin
            failures++;
            $display("FAIL reset_por: rd_data=%h rd_busy=%b busy_count=%0d required all 0",
                     rd_data, rd_busy, busy_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Store data and a reservation, then pulse reset mid-cycle.
        write_reg(5'd2, 32'h0000_0022);
        reserve_reg(5'd3);
        checks++;
        if (rd_data[DW-1:0] !== 32'h0000_0022 || rd_busy !== 2'b10 || busy_count !== 6'd1) begin
            failures++;
            $display("FAIL reset_pre: rd_data0=%h rd_busy=%b busy_count=%0d required 00000022 10 1",
                     rd_data[DW-1:0], rd_busy, busy_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_count !== '0) begin
            failures++;
            $display("FAIL reset_async: rd_data=%h rd_busy=%b busy_count=%0d required all 0",
                     rd_data, rd_busy, busy_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_count !== '0) begin
            failures++;
            $display("FAIL reset_after: rd_data=%h rd_busy=%b busy_count=%0d required all 0",
                     rd_data, rd_busy, busy_count);
        end
    endtask

    task automatic test_write_sweep();
        logic [DW-1:0] v;
        logic [DW-1:0] e;
        for (int s = 1; s < 32; s++) begin
            v = $urandom;
            exp_q.push_back(v);
            write_reg(AW'(s), v);
        end

        // Select 0 on the write port must store nothing and read as zero.
        write_reg(5'd0, 32'hDEAD_BEEF);
        set_sel(5'd0, 5'd0);
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            failures++;
            $display("FAIL sel0_read: rd_data=%h rd_busy=%b required 0 0", rd_data, rd_busy);
        end

        for (int s = 1; s < 32; s++) begin
            e = exp_q.pop_front();
            set_sel(AW'(s), AW'(s));
            #1;
            checks++;
            if (rd_data[RF_PORT_SBUS*DW +: DW] !== e || rd_data[RF_PORT_ALU*DW +: DW] !== e) begin
                failures++;
                $display("FAIL sweep_r%0d: sbus=%h alu=%h required %h", s,
                         rd_data[RF_PORT_SBUS*DW +: DW], rd_data[RF_PORT_ALU*DW +: DW], e);
            end
        end
        cycle();
    endtask

    task automatic test_scoreboard();
        set_sel(5'd5, 5'd0);
        reserve_reg(5'd5);
        checks++;
        if (rd_busy !== 2'b01 || busy_count !== 6'd1) begin
            failures++;
            $display("FAIL sb_reserve: rd_busy=%b busy_count=%0d required 01 1", rd_busy, busy_count);
        end
        write_reg(5'd5, 32'h1234_5678);
        checks++;
        if (rd_busy !== 2'b00 || busy_count !== 6'd0 || rd_data[DW-1:0] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL sb_release: rd_busy=%b busy_count=%0d data=%h required 00 0 12345678",
                     rd_busy, busy_count, rd_data[DW-1:0]);
        end
    endtask

    task automatic test_simultaneous();
        set_sel(5'd7, 5'd7);
        reserve_en     = 1'b1;
        reserve_select = 5'd7;
        write_select   = 5'd7;
        sbus_in        = 32'hA5A5_A5A5;
        cycle();
        idle();
        checks++;
        if (rd_data !== {32'hA5A5_A5A5, 32'hA5A5_A5A5} || rd_busy !== 2'b11 || busy_count !== 6'd1) begin
            failures++;
            $display("FAIL same_reg: rd_data=%h rd_busy=%b busy_count=%0d required a5a5a5a5a5a5a5a5 11 1",
                     rd_data, rd_busy, busy_count);
        end

        // Reserve r3 while writing r4 (after reserving r4 first).
        reserve_reg(5'd4);
        set_sel(5'd3, 5'd4);
        reserve_en     = 1'b1;
        reserve_select = 5'd3;
        write_select   = 5'd4;
        sbus_in        = 32'h0000_0044;
        cycle();
        idle();
        checks++;
        if (rd_busy !== 2'b01 || busy_count !== 6'd2 || rd_data[DW +: DW] !== 32'h0000_0044) begin
            failures++;
            $display("FAIL diff_reg: rd_busy=%b busy_count=%0d r4=%h required 01 2 00000044",
                     rd_busy, busy_count, rd_data[DW +: DW]);
        end

        write_reg(5'd7, 32'h0000_0077);
        write_reg(5'd3, 32'h0000_0033);
        checks++;
        if (busy_count !== 6'd0) begin
            failures++;
            $display("FAIL sim_clear: busy_count=%0d required 0", busy_count);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_pre;
        logic          exp_busy_pre;
        write_reg(5'd9, 32'h9999_0000);
        set_sel(5'd9, 5'd0);
        write_select = 5'd9;
        sbus_in      = 32'hCAFE_F00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'hCAFE_F00D;
`else
        exp_pre = 32'h9999_0000;
`endif
        checks++;
        if (rd_data[DW-1:0] !== exp_pre || rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL bypass_pre: rd_data0=%h rd_busy0=%b required %h 0",
                     rd_data[DW-1:0], rd_busy[0], exp_pre);
        end
        cycle();
        idle();
        checks++;
        if (rd_data[DW-1:0] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL bypass_post: rd_data0=%h required cafef00d", rd_data[DW-1:0]);
        end

        // Write with a same-register reservation in the same cycle.
        write_select   = 5'd9;
        sbus_in        = 32'h0BAD_CAFE;
        reserve_en     = 1'b1;
        reserve_select = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre      = 32'h0BAD_CAFE;
        exp_busy_pre = 1'b1;
`else
        exp_pre      = 32'hCAFE_F00D;
        exp_busy_pre = 1'b0;
`endif
        checks++;
        if (rd_data[DW-1:0] !== exp_pre || rd_busy[0] !== exp_busy_pre) begin
            failures++;
            $display("FAIL bypass_rsv_pre: rd_data0=%h rd_busy0=%b required %h %b",
                     rd_data[DW-1:0], rd_busy[0], exp_pre, exp_busy_pre);
        end
        cycle();
        idle();
        checks++;
        if (rd_data[DW-1:0] !== 32'h0BAD_CAFE || rd_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL bypass_rsv_post: rd_data0=%h rd_busy0=%b required 0badcafe 1",
                     rd_data[DW-1:0], rd_busy[0]);
        end
        write_reg(5'd9, 32'h0000_0009);
    endtask

    task automatic test_saturation();
        for (int s = 1; s < 32; s++) begin
            reserve_reg(AW'(s));
            if (s == 16) begin
                checks++;
                if (busy_count !== 6'd16) begin
                    failures++;
                    $display("FAIL sat_half: busy_count=%0d required 16", busy_count);
                end
            end
        end
        set_sel(5'd1, 5'd31);
        #1;
        checks++;
        if (busy_count !== 6'd31 || rd_busy !== 2'b11) begin
            failures++;
            $display("FAIL sat_full: busy_count=%0d rd_busy=%b required 31 11", busy_count, rd_busy);
        end
        reserve_reg(5'd0);
        checks++;
        if (busy_count !== 6'd31) begin
            failures++;
            $display("FAIL sat_r0: busy_count=%0d required 31", busy_count);
        end

        // Mid-cycle reset discards every reservation at once.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_count !== 6'd0 || rd_busy !== 2'b00 || rd_data !== '0) begin
            failures++;
            $display("FAIL sat_reset: busy_count=%0d rd_busy=%b rd_data=%h required 0 00 0",
                     busy_count, rd_busy, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        rd_select = '0;
        idle();

        test_reset();
        test_write_sweep();
        test_scoreboard();
        test_simultaneous();
        test_bypass();
        test_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Next-generation register file for the datapath, replacing the unclocked single-write / two-read file.
- Clocked, parametrised in width, depth and read-port count; port 0 feeds the S-bus and port 1 feeds the ALU.
- Adds a per-register busy scoreboard so decode can stall on outstanding long-latency writes, such as load returns.
- Register 0 reads as zero, and select 0 on the write port means "no write", as in the existing datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, select width; depth is 2**ADDR_W, and register 0 is hardwired to zero.
- NUM_RD, 2, number of combinational read ports (0 = S-bus, 1 = ALU, higher ports are spare).

Ports:
- clk  in  1  Clock; rising-edge active.
- rst_n  in  1  Asynchronous active-low reset.
- sbus_in  in  DATA_W  Write data.
- write_select  in  ADDR_W  Write target; 0 = no write.
- reserve_en  in  1  Mark reserve_select busy (pending write issued).
- reserve_select  in  ADDR_W  Register to reserve.
- rd_select  in  NUM_RD*ADDR_W  Read selects; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  Read data per port.
- rd_busy  out  NUM_RD  Busy flag of the selected register per port.
- busy_count  out  ADDR_W+1  Number of registers currently busy.

Behaviour:
- Storage: regs[1..2**ADDR_W-1], DATA_W each; busy[1..2**ADDR_W-1], one bit each. No storage for register 0.
- Reset (rst_n low, asynchronous): all regs = 0 and all busy = 0 immediately.
  - Consequently every output reads 0 while in reset: rd_data, rd_busy and busy_count.
  - Reset asserted mid-operation discards in-flight reservations; there is no recovery.
- Write: on posedge clk, if write_select != 0 then regs[write_select] <= sbus_in and busy[write_select] <= 0.
  - Writing a register that is not busy is legal.
- Reserve: on posedge clk, if reserve_en && reserve_select != 0 then busy[reserve_select] <= 1.
  - reserve_en with select 0 is ignored.
- Same register written and reserved in the same cycle: data is written and busy ends at 1 (the newer reservation wins).
- Reads: combinational, zero cycles of latency.
  - rd_data[p] = 0 and rd_busy[p] = 0 when the select is 0.
  - Otherwise rd_data[p] = regs[sel] and rd_busy[p] = busy[sel].
  - Bypass behaviour is controlled by the optional feature below.
- busy_count: combinational population count of the busy vector, range 0..2**ADDR_W-1.
  - It reflects registered state only; same-cycle reserves and writes are not counted until the next cycle.
- Multiple read ports may select the same register; each returns an identical result.
- No write conflicts are possible: there is one write port.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when write_select != 0 and equals rd_select[p], then rd_data[p] = sbus_in and rd_busy[p] = 0 in the same cycle (write-to-read forwarding).
  - Exception: if reserve_en targets the same register in that cycle, rd_busy[p] = 1.
- Undefined: reads show pre-edge register contents; the new value is visible the cycle after the write.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants RF_DATA_W = 32, RF_ADDR_W = 5, RF_NUM_RD = 2;
  - port index constants RF_PORT_SBUS = 0, RF_PORT_ALU = 1;
  - typedefs rf_addr_t and rf_data_t.
- One natural sub-module: regfile_rdport, a single read mux with zero-register masking and optional bypass, instantiated NUM_RD times in a generate loop.
- The scoreboard and popcount stay in the top module.

Test Plan:
1. Reset then read: pulse rst_n low mid-cycle with stored data present -> all rd_data = 0 and busy_count = 0 immediately, before any clock edge.
2. Write/read sweep:
   - Stimulus: for sel 1..31 write $random with write_select = sel, then idle with write_select = 0.
   - Required response: the S-bus port and the ALU port both return the written value.
   - Also drive sel 0 with data 0xDEADBEEF -> reads 0 and nothing is stored.
3. Scoreboard:
   - Reserve r5 -> next cycle rd_busy = 1 on a port selecting r5, and busy_count = 1.
   - Write r5 = 0x12345678 -> next cycle busy = 0, data = 0x12345678, busy_count = 0.
4. Simultaneous events:
   - Same cycle, reserve r7 and write r7 = 0xA5A5A5A5 -> data = 0xA5A5A5A5, busy stays 1.
   - Same cycle, reserve r3 and write r4 -> r3 busy, r4 not busy.
5. Bypass:
   - With REGFILE_BYPASS_EN: write r9 = 0xCAFEF00D with rd_select port0 = 9 -> rd_data[0] = 0xCAFEF00D in the same cycle.
   - Without the macro: the old value is shown, and the new one appears the next cycle.
6. Saturation: reserve all of r1..r31 on consecutive cycles -> busy_count = 31; reserve r0 -> busy_count still 31.
